// File: rtl/fft_out_serializer_pkg.sv
// Shared definitions for the FFT stage, its input-side index mapper and the
// output serializer: frame geometry defaults, serializer state encoding and the
// k*MSB word packing helper.
package fft_out_serializer_pkg;

  // Default frame geometry (FFT points, bits per packed complex word).
  localparam int unsigned FftN   = 32;
  localparam int unsigned FftMsb = 16;

  // Width of a word index for an N-point frame.
  function automatic int unsigned addr_w(input int unsigned n);
    return $clog2(n);
  endfunction

  localparam int unsigned AddrW  = $clog2(FftN);
  localparam int unsigned FrameW = FftN * FftMsb;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } state_e;

  // Word k of a packed frame lives at bits [k*MSB +: MSB].
  function automatic logic [FftMsb-1:0] word_slice(input logic [FrameW-1:0] frame,
                                                   input logic [AddrW-1:0]  k);
    return frame[k*FftMsb +: FftMsb];
  endfunction

endpackage

// File: rtl/fft_out_serializer_word_select.sv
// Combinational selection of word k from a packed N*MSB frame.
// Ports:
//   frame_i : packed frame, word k = bits [k*MSB +: MSB]
//   sel_i   : word index k
//   word_o  : selected word
// Kept as its own block so a pipeline stage can be inserted if N grows.
module fft_out_serializer_word_select
  import fft_out_serializer_pkg::*;
#(
  parameter int unsigned N     = FftN,
  parameter int unsigned MSB   = FftMsb,
  parameter int unsigned AddrW = $clog2(N)
) (
  input  logic [N*MSB-1:0] frame_i,
  input  logic [AddrW-1:0] sel_i,
  output logic [MSB-1:0]   word_o
);

  always_comb begin
    word_o = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_i == AddrW'(k)) begin
        word_o = frame_i[k*MSB +: MSB];
      end
    end
  end

endmodule

// File: rtl/fft_out_serializer.sv
// Snapshots a completed FFT frame from the wide result bus on calc_finish and
// streams it out one word per cycle, ascending index, over valid/ready.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   calc_finish  : one-cycle pulse, fft_data_in holds a valid frame
//   fft_data_in  : packed frame, word k = bits [k*MSB +: MSB]
//   data_out     : current word (bit-exact copy of the captured word)
//   data_valid   : data_out/addr_out/last valid
//   data_ready   : downstream accepts the word this cycle
//   addr_out     : index of the word on data_out
//   last         : high with word N-1
//   busy         : a frame is held and not yet fully accepted
//   frame_done   : one-cycle pulse after word N-1 is accepted
//   overrun      : sticky, a frame arrived while busy and was dropped
module fft_out_serializer
  import fft_out_serializer_pkg::*;
#(
  parameter int unsigned N   = FftN,
  parameter int unsigned MSB = FftMsb
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 calc_finish,
  input  logic [N*MSB-1:0]     fft_data_in,
  output logic [MSB-1:0]       data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic [$clog2(N)-1:0] addr_out,
  output logic                 last,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int unsigned AW = $clog2(N);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [N*MSB-1:0] shadow_q, shadow_d;
  logic            overrun_q, overrun_d;
  logic            frame_done_q, frame_done_d;

  logic            is_send;
  logic            at_last;
  logic            xfer;
  logic [MSB-1:0]  sel_word;

  assign is_send = (state_q == StSend);
  assign at_last = (cnt_q == AW'(N - 1));
  assign xfer    = is_send && data_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (calc_finish) begin
          shadow_d = fft_data_in;
          cnt_d    = '0;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (xfer && at_last) begin
          frame_done_d = 1'b1;
          if (calc_finish) begin
            // Back-to-back frame: capture and continue without an idle cycle.
            shadow_d = fft_data_in;
            cnt_d    = '0;
          end else begin
            // Counter is left at N-1; it is only reloaded on capture.
            state_d = StIdle;
          end
        end else begin
          if (xfer) begin
            cnt_d = cnt_q + AW'(1);
          end
          if (calc_finish) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Shadow contents are don't-care after reset, so no reset on the wide register.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  fft_out_serializer_word_select #(
    .N     (N),
    .MSB   (MSB),
    .AddrW (AW)
  ) u_word_select (
    .frame_i (shadow_q),
    .sel_i   (cnt_q),
    .word_o  (sel_word)
  );

  // Word/index outputs are forced to zero outside SEND so the reset values hold
  // regardless of the stale shadow and counter.
  assign data_valid = is_send;
  assign data_out   = is_send ? sel_word : '0;
  assign addr_out   = is_send ? cnt_q : '0;
  assign last       = is_send && at_last;
  assign busy       = is_send;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule
